// File: rtl/fproc_meas_pkg.sv
// Shared types and helpers for the fproc measurement buffer: per-core FSM states,
// request mode encodings and result-word layout.
package fproc_meas_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam logic MODE_LATEST = 1'b0;
  localparam logic MODE_NEXT   = 1'b1;

  function automatic int unsigned err_bit_pos(int unsigned data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/fproc_meas_core_ctrl.sv
// Per-core request FSM: latches channel/mode, waits for the next strobe or times out,
// and presents a one-cycle ready pulse with a held result word.
module fproc_meas_core_ctrl
  import fproc_meas_pkg::*;
#(
  parameter int unsigned MeasWidth = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 8,
  parameter int unsigned Timeout   = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [IdWidth-1:0]   id_i,
  output logic [IdWidth-2:0]   ch_o,
  input  logic                 sel_hit_i,
  input  logic                 sel_valid_i,
  input  logic [MeasWidth-1:0] sel_meas_i,
  input  logic [MeasWidth-1:0] sel_buf_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o
);

  localparam int unsigned ChWidth  = IdWidth - 1;
  localparam int unsigned CntWidth = $clog2(Timeout);
  localparam int unsigned ErrBit   = err_bit_pos(DataWidth);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(Timeout - 1);

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [ChWidth-1:0]   ch_q, ch_d;
  logic [DataWidth-1:0] data_q, data_d;

  function automatic logic [DataWidth-1:0] pack_word(logic err, logic [MeasWidth-1:0] val);
    logic [DataWidth-1:0] w;
    w                = '0;
    w[ErrBit]        = err;
    w[MeasWidth-1:0] = val;
    return w;
  endfunction

  // In IDLE the channel comes straight from the request so the enable cycle can bypass.
  always_comb begin
    ch_o = (state_q == StIdle) ? id_i[ChWidth-1:0] : ch_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          ch_d = id_i[ChWidth-1:0];
          if (!sel_hit_i) begin
            data_d  = pack_word(1'b1, '0);
            state_d = StResp;
          end else if (id_i[IdWidth-1] == MODE_NEXT) begin
            cnt_d   = '0;
            state_d = StWait;
          end else begin
            data_d  = pack_word(1'b0, sel_valid_i ? sel_meas_i : sel_buf_i);
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (sel_valid_i) begin
          data_d  = pack_word(1'b0, sel_meas_i);
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          data_d  = pack_word(1'b1, sel_buf_i);
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = (state_q == StResp);
  assign data_o  = data_q;

endmodule

// File: rtl/fproc_meas_buf.sv
// Measurement buffer serving N_CORES concurrent fproc requests: per-channel value
// registers plus a channel-select mux and request controller per core.
module fproc_meas_buf
  import fproc_meas_pkg::*;
#(
  parameter int unsigned N_CORES        = 5,
  parameter int unsigned N_MEAS         = 8,
  parameter int unsigned MEAS_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FPROC_ID_WIDTH = 8,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MEAS_WIDTH-1:0]     meas         [N_MEAS],
  input  logic [N_MEAS-1:0]         meas_valid,
  input  logic [FPROC_ID_WIDTH-1:0] fproc_id     [N_CORES],
  input  logic [N_CORES-1:0]        fproc_enable,
  output logic [DATA_WIDTH-1:0]     fproc_data   [N_CORES],
  output logic [N_CORES-1:0]        fproc_ready
);

  logic [MEAS_WIDTH-1:0] meas_buf_q [N_MEAS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned j = 0; j < N_MEAS; j++) meas_buf_q[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < N_MEAS; j++) begin
        if (meas_valid[j]) meas_buf_q[j] <= meas[j];
      end
    end
  end

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    logic [FPROC_ID_WIDTH-2:0] ch;
    logic                      hit;
    logic                      valid;
    logic [MEAS_WIDTH-1:0]     sel_meas;
    logic [MEAS_WIDTH-1:0]     sel_buf;

    // A miss (index >= N_MEAS) is reported to the controller as an error request.
    always_comb begin
      hit      = 1'b0;
      valid    = 1'b0;
      sel_meas = '0;
      sel_buf  = '0;
      for (int unsigned j = 0; j < N_MEAS; j++) begin
        if (32'(ch) == j) begin
          hit      = 1'b1;
          valid    = meas_valid[j];
          sel_meas = meas[j];
          sel_buf  = meas_buf_q[j];
        end
      end
    end

    fproc_meas_core_ctrl #(
      .MeasWidth(MEAS_WIDTH),
      .DataWidth(DATA_WIDTH),
      .IdWidth  (FPROC_ID_WIDTH),
      .Timeout  (TIMEOUT)
    ) u_ctrl (
      .clk_i      (clk),
      .rst_ni     (reset),
      .enable_i   (fproc_enable[c]),
      .id_i       (fproc_id[c]),
      .ch_o       (ch),
      .sel_hit_i  (hit),
      .sel_valid_i(valid),
      .sel_meas_i (sel_meas),
      .sel_buf_i  (sel_buf),
      .ready_o    (fproc_ready[c]),
      .data_o     (fproc_data[c])
    );
  end

endmodule

// File: doc/fproc_meas_buf.md
FPROC_MEAS_BUF -- requirements
Module: fproc_meas_buf

Interface
REQ-001 SHALL have parameter N_CORES, default 5: number of requesting cores.
REQ-002 SHALL have parameter N_MEAS, default 8: number of measurement channels.
REQ-003 SHALL have parameter MEAS_WIDTH, default 4: bits per measurement; 1 <= MEAS_WIDTH <= DATA_WIDTH-1.
REQ-004 SHALL have parameter DATA_WIDTH, default 32: result word width.
REQ-005 SHALL have parameter FPROC_ID_WIDTH, default 8: request id width; MSB is the mode bit, the remaining bits form the channel index.
REQ-006 SHALL have parameter TIMEOUT, default 1024: wait-mode cycle limit, >= 2.
REQ-007 Ports SHALL be clk, input, 1: the single clock.
REQ-008 Ports SHALL be reset, input, 1: synchronous, active-low reset.
REQ-009 Ports SHALL be meas, input, [MEAS_WIDTH-1:0] x N_MEAS (unpacked): measurement values.
REQ-010 Ports SHALL be meas_valid, input, N_MEAS: per-channel one-cycle strobe qualifying meas.
REQ-011 Ports SHALL be fproc_id, input, [FPROC_ID_WIDTH-1:0] x N_CORES: request id per core.
REQ-012 Ports SHALL be fproc_enable, input, N_CORES: per-core request strobe.
REQ-013 Ports SHALL be fproc_data, output, [DATA_WIDTH-1:0] x N_CORES: result word per core.
REQ-014 Ports SHALL be fproc_ready, output, N_CORES: per-core one-cycle result strobe.

Function
REQ-015 Each channel SHALL hold a registered value buffer, updated on every cycle its meas_valid is high.
REQ-016 Each core SHALL run an independent FSM with states IDLE, WAIT, RESP.
REQ-017 In IDLE with fproc_enable high, the FSM SHALL latch the channel index and the mode from fproc_id.
REQ-018 Mode 0 (latest): the FSM SHALL go to RESP; fproc_ready SHALL pulse on the cycle after enable.
REQ-019 Mode 0 data SHALL be the buffer value including any meas_valid in the enable cycle (write-through bypass).
REQ-020 Mode 1 (next): the FSM SHALL go to WAIT and clear a per-core timeout counter.
REQ-021 In WAIT, only a meas_valid strictly after the enable cycle SHALL complete the request; meas_valid in the enable cycle SHALL be ignored.
REQ-022 On a qualifying meas_valid in WAIT, the FSM SHALL go to RESP; fproc_ready SHALL pulse on the next cycle with that measurement value.
REQ-023 In WAIT, the counter SHALL increment each cycle; on reaching TIMEOUT-1 without a qualifying strobe, the FSM SHALL go to RESP with the error bit set.
REQ-024 RESP SHALL last exactly one cycle with fproc_ready high, then return to IDLE.
REQ-025 The result word SHALL be: bit DATA_WIDTH-1 = error; bits MEAS_WIDTH-1:0 = value; all other bits zero.
REQ-026 A channel index >= N_MEAS SHALL complete in one cycle (either mode) with error=1 and value=0.
REQ-027 On timeout, the value field SHALL be the channel's current buffer contents.
REQ-028 fproc_enable outside IDLE SHALL be ignored, with no queuing.
REQ-029 Any number of cores SHALL be servable in the same cycle, including on the same channel, with no arbitration stall.
REQ-030 fproc_data SHALL hold its last value between ready pulses.

Reset
REQ-031 While reset is low at a clk edge, all FSMs SHALL go to IDLE and all counters clear.
REQ-032 While reset is low at a clk edge, all channel buffers SHALL be zeroed, fproc_ready SHALL be 0, and fproc_data SHALL be 0.
REQ-033 Reset asserted during WAIT SHALL abandon the request with no ready pulse.
REQ-034 The first enable SHALL be accepted on the first cycle with reset high.

Structure
REQ-035 Package fproc_meas_pkg SHALL define the FSM state enum, the mode encodings (MODE_LATEST=0, MODE_NEXT=1), and the error-bit position function of DATA_WIDTH.
REQ-036 The per-core FSM and counter SHALL be sub-module fproc_meas_core_ctrl, instantiated N_CORES times by generate.
REQ-037 Channel buffers and the channel-select muxes SHALL reside in the top level.

Verification
REQ-038 Latest mode: ch2 meas=5 valid at t0; core0 enable id=0x02 at t3 -> ready at t4, data=0x00000005.
REQ-039 Bypass: core1 enable id=0x03 and ch3 meas=9 valid same cycle t0 -> ready t1, data=0x00000009.
REQ-040 Next mode: core0 id=0x81 at t0 with ch1 valid at t0 (ignored), ch1 meas=7 valid at t6 -> ready t7, data=0x00000007.
REQ-041 Timeout: TIMEOUT=16, core2 id=0x84, no ch4 strobe -> ready exactly 17 cycles after enable, data=0x80000000 | buffer.
REQ-042 Errors/concurrency: core3 id=0x0A (N_MEAS=8) -> ready next cycle, data=0x80000000; all 5 cores id=0x00 same cycle -> 5 simultaneous ready pulses, equal data.
REQ-043 Reset mid-WAIT: core0 in WAIT, reset low 1 cycle -> no ready pulse; data=0; buffers=0; new request accepted after.
